// File: rtl/aha_ahb_code_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aha_ahb_code_arbiter
// Purpose  : Two-master to one-slave AHB-Lite arbiter in front of the code
//            SRAM. M0 (D-code) has priority and M1 (I-code) is low priority.
//            Each master has a one-deep hold register that captures a losing
//            address phase and replays it later. A wait counter promotes a
//            starved M1 after MAX_WAIT consecutive lost slots.
// Revision : 1.0 - initial release
// ============================================================================
module aha_ahb_code_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL_M0,
  input  logic [1:0]  HTRANS_M0,
  input  logic [31:0] HADDR_M0,
  input  logic        HWRITE_M0,
  input  logic [2:0]  HSIZE_M0,
  input  logic [31:0] HWDATA_M0,
  output logic        HREADY_M0,
  output logic [1:0]  HRESP_M0,
  input  logic        HSEL_M1,
  input  logic [1:0]  HTRANS_M1,
  input  logic [31:0] HADDR_M1,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M1,
  output logic        HREADY_M1,
  output logic [1:0]  HRESP_M1,
  output logic [31:0] HRDATA_M,
  output logic        HSEL_S,
  output logic [1:0]  HTRANS_S,
  output logic [31:0] HADDR_S,
  output logic        HWRITE_S,
  output logic [2:0]  HSIZE_S,
  output logic [31:0] HWDATA_S,
  output logic        HREADY_S,
  input  logic        HREADYOUT_S,
  input  logic [1:0]  HRESP_S,
  input  logic [31:0] HRDATA_S
);

  localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_RESP_OKAY    = 2'b00;
  localparam logic [3:0] c_MAX_WAIT     = 4'(MAX_WAIT);
  localparam logic [3:0] c_WAIT_SAT     = 4'hF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  owner_t      r_owner;
  logic        r_pend_m0, r_pend_m1;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_hold_addr_m0, r_hold_addr_m1;
  logic        r_hold_write_m0, r_hold_write_m1;
  logic [2:0]  r_hold_size_m0, r_hold_size_m1;
  logic [31:0] r_last_addr;
  logic        r_last_write;
  logic [2:0]  r_last_size;

  logic        w_slot_open;
  logic        w_accept_m0, w_accept_m1;
  logic        w_req_m0, w_req_m1;
  logic        w_gnt_m0, w_gnt_m1;
  logic        w_cap_m0, w_cap_m1;
  logic [31:0] w_src_addr_m0, w_src_addr_m1;
  logic        w_src_write_m0, w_src_write_m1;
  logic [2:0]  w_src_size_m0, w_src_size_m1;
  logic        w_unused;

  // SEQ/NONSEQ distinction is dropped: every forwarded beat is NONSEQ
  assign w_unused = ^{HTRANS_M0[0], HTRANS_M1[0]};

  assign w_slot_open = HREADYOUT_S;

  // Reset is folded into accept so the slave sees IDLE while HRESETn is low
  assign w_accept_m0 = HRESETn & HSEL_M0 & HTRANS_M0[1] & HREADY_M0;
  assign w_accept_m1 = HRESETn & HSEL_M1 & HTRANS_M1[1] & HREADY_M1;
  assign w_req_m0    = r_pend_m0 | w_accept_m0;
  assign w_req_m1    = r_pend_m1 | w_accept_m1;

  // M1 wins when alone, or when it has been pending and starved long enough
  assign w_gnt_m1 = w_slot_open & w_req_m1 &
                    (~w_req_m0 | (r_pend_m1 & (r_wait_cnt >= c_MAX_WAIT)));
  assign w_gnt_m0 = w_slot_open & w_req_m0 & ~w_gnt_m1;

  // A grant implies an open slot, so this also covers capture during a stall
  assign w_cap_m0 = w_accept_m0 & ~w_gnt_m0;
  assign w_cap_m1 = w_accept_m1 & ~w_gnt_m1;

  assign w_src_addr_m0  = r_pend_m0 ? r_hold_addr_m0  : HADDR_M0;
  assign w_src_write_m0 = r_pend_m0 ? r_hold_write_m0 : HWRITE_M0;
  assign w_src_size_m0  = r_pend_m0 ? r_hold_size_m0  : HSIZE_M0;
  assign w_src_addr_m1  = r_pend_m1 ? r_hold_addr_m1  : HADDR_M1;
  assign w_src_write_m1 = r_pend_m1 ? r_hold_write_m1 : HWRITE_M1;
  assign w_src_size_m1  = r_pend_m1 ? r_hold_size_m1  : HSIZE_M1;

  // Address-phase mux; with no grant the address outputs keep the last beat
  always_comb begin
    HSEL_S   = 1'b0;
    HTRANS_S = c_TRANS_IDLE;
    HADDR_S  = r_last_addr;
    HWRITE_S = r_last_write;
    HSIZE_S  = r_last_size;
    if (w_gnt_m0) begin
      HSEL_S   = 1'b1;
      HTRANS_S = c_TRANS_NONSEQ;
      HADDR_S  = w_src_addr_m0;
      HWRITE_S = w_src_write_m0;
      HSIZE_S  = w_src_size_m0;
    end else if (w_gnt_m1) begin
      HSEL_S   = 1'b1;
      HTRANS_S = c_TRANS_NONSEQ;
      HADDR_S  = w_src_addr_m1;
      HWRITE_S = w_src_write_m1;
      HSIZE_S  = w_src_size_m1;
    end
  end

  // Data-phase routing follows the owner; a non-owner stalls only if pending
  assign HREADY_M0 = (r_owner == OWN_M0) ? HREADYOUT_S : ~r_pend_m0;
  assign HREADY_M1 = (r_owner == OWN_M1) ? HREADYOUT_S : ~r_pend_m1;
  assign HRESP_M0  = (r_owner == OWN_M0) ? HRESP_S : c_RESP_OKAY;
  assign HRESP_M1  = (r_owner == OWN_M1) ? HRESP_S : c_RESP_OKAY;
  assign HRDATA_M  = HRDATA_S;
  assign HREADY_S  = HREADYOUT_S;
  assign HWDATA_S  = (r_owner == OWN_M0) ? HWDATA_M0 :
                     (r_owner == OWN_M1) ? HWDATA_M1 : 32'h0;

  // Arbitration state: data-phase owner, pending flags and M1 starvation count
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner    <= OWN_NONE;
      r_pend_m0  <= 1'b0;
      r_pend_m1  <= 1'b0;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_slot_open) begin
        r_owner <= w_gnt_m0 ? OWN_M0 : (w_gnt_m1 ? OWN_M1 : OWN_NONE);
        if (w_gnt_m1)
          r_wait_cnt <= 4'd0;
        else if (r_pend_m1 && (r_wait_cnt != c_WAIT_SAT))
          r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      if (w_cap_m0)
        r_pend_m0 <= 1'b1;
      else if (w_gnt_m0)
        r_pend_m0 <= 1'b0;
      if (w_cap_m1)
        r_pend_m1 <= 1'b1;
      else if (w_gnt_m1)
        r_pend_m1 <= 1'b0;
    end
  end

  // Hold registers for captured beats and the last forwarded address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hold_addr_m0  <= 32'h0;
      r_hold_write_m0 <= 1'b0;
      r_hold_size_m0  <= 3'b000;
      r_hold_addr_m1  <= 32'h0;
      r_hold_write_m1 <= 1'b0;
      r_hold_size_m1  <= 3'b000;
      r_last_addr     <= 32'h0;
      r_last_write    <= 1'b0;
      r_last_size     <= 3'b000;
    end else begin
      if (w_cap_m0) begin
        r_hold_addr_m0  <= HADDR_M0;
        r_hold_write_m0 <= HWRITE_M0;
        r_hold_size_m0  <= HSIZE_M0;
      end
      if (w_cap_m1) begin
        r_hold_addr_m1  <= HADDR_M1;
        r_hold_write_m1 <= HWRITE_M1;
        r_hold_size_m1  <= HSIZE_M1;
      end
      if (HSEL_S) begin
        r_last_addr  <= HADDR_S;
        r_last_write <= HWRITE_S;
        r_last_size  <= HSIZE_S;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aha_ahb_code_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aha_ahb_code_arbiter
// Purpose  : Scoreboard bench for the code-region arbiter. Directed scenarios
//            push the expected slave address-phase order and per-master
//            data-phase results; monitors pop and compare them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aha_ahb_code_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL_M0, HSEL_M1;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic [31:0] HADDR_M0, HADDR_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1;
  logic [31:0] HWDATA_M0, HWDATA_M1;
  logic        HREADY_M0, HREADY_M1;
  logic [1:0]  HRESP_M0, HRESP_M1;
  logic [31:0] HRDATA_M;
  logic        HSEL_S;
  logic [1:0]  HTRANS_S;
  logic [31:0] HADDR_S;
  logic        HWRITE_S;
  logic [2:0]  HSIZE_S;
  logic [31:0] HWDATA_S;
  logic        HREADY_S;
  logic        HREADYOUT_S;
  logic [1:0]  HRESP_S;
  logic [31:0] HRDATA_S;

  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, ERR = 2'b01;

  typedef struct { logic [31:0] addr; logic wr; } sexp_t;
  typedef struct { logic wr; logic [31:0] data; logic [1:0] resp; } mexp_t;

  sexp_t sq[$];
  mexp_t q0[$], q1[$];
  sexp_t se;
  mexp_t me;
  int    n_total = 0;
  int    n_bad   = 0;
  logic  dp0, dp1;
  logic [31:0] s_dp_addr;

  aha_ahb_code_arbiter #(.MAX_WAIT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_M0(HSEL_M0), .HTRANS_M0(HTRANS_M0), .HADDR_M0(HADDR_M0),
    .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
    .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0),
    .HSEL_M1(HSEL_M1), .HTRANS_M1(HTRANS_M1), .HADDR_M1(HADDR_M1),
    .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
    .HREADY_M1(HREADY_M1), .HRESP_M1(HRESP_M1),
    .HRDATA_M(HRDATA_M),
    .HSEL_S(HSEL_S), .HTRANS_S(HTRANS_S), .HADDR_S(HADDR_S),
    .HWRITE_S(HWRITE_S), .HSIZE_S(HSIZE_S), .HWDATA_S(HWDATA_S),
    .HREADY_S(HREADY_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA_S(HRDATA_S)
  );

  always #5 HCLK = ~HCLK;

  // Slave model: read data is a fixed function of the data-phase address
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return 32'hCAFE0000 | {24'h0, a[15:8]};
  endfunction
  assign HRDATA_S = exp_rd(s_dp_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv_m0(input logic [1:0] tr, input logic [31:0] a, input logic wr);
    HSEL_M0 = (tr != IDLE); HTRANS_M0 = tr; HADDR_M0 = a; HWRITE_M0 = wr;
  endtask

  task automatic drv_m1(input logic [1:0] tr, input logic [31:0] a, input logic wr);
    HSEL_M1 = (tr != IDLE); HTRANS_M1 = tr; HADDR_M1 = a; HWRITE_M1 = wr;
  endtask

  task automatic push_s(input logic [31:0] a, input logic wr);
    sexp_t e;
    e.addr = a; e.wr = wr;
    sq.push_back(e);
  endtask

  task automatic push_m(input int m, input logic wr, input logic [31:0] d, input logic [1:0] r);
    mexp_t e;
    e.wr = wr; e.data = d; e.resp = r;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Data-phase trackers for each master and the slave
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp0 <= 1'b0; dp1 <= 1'b0; s_dp_addr <= 32'h0;
    end else begin
      if (HREADY_M0) dp0 <= HSEL_M0 & HTRANS_M0[1];
      if (HREADY_M1) dp1 <= HSEL_M1 & HTRANS_M1[1];
      if (HREADYOUT_S && HSEL_S && HTRANS_S[1]) s_dp_addr <= HADDR_S;
    end
  end

  // Mid-cycle monitor: pops slave-order and master-result expectations
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (HSEL_S && HTRANS_S[1] && HREADYOUT_S) begin
        if (sq.size() == 0) chk("s_extra", 32'd1, 32'd0);
        else begin
          se = sq.pop_front();
          chk("s_addr", HADDR_S, se.addr);
          chk("s_write", {31'd0, HWRITE_S}, {31'd0, se.wr});
          chk("s_trans", {30'd0, HTRANS_S}, {30'd0, NSQ});
          chk("s_size", {29'd0, HSIZE_S}, 32'd2);
        end
      end
      if (dp0 && HREADY_M0) begin
        if (q0.size() == 0) chk("m0_extra", 32'd1, 32'd0);
        else begin
          me = q0.pop_front();
          chk("m0_resp", {30'd0, HRESP_M0}, {30'd0, me.resp});
          if (!me.wr && me.resp == OKAY) chk("m0_rdata", HRDATA_M, me.data);
        end
      end
      if (dp1 && HREADY_M1) begin
        if (q1.size() == 0) chk("m1_extra", 32'd1, 32'd0);
        else begin
          me = q1.pop_front();
          chk("m1_resp", {30'd0, HRESP_M1}, {30'd0, me.resp});
          if (!me.wr && me.resp == OKAY) chk("m1_rdata", HRDATA_M, me.data);
        end
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    drv_m0(IDLE, 32'h0, 1'b0); drv_m1(IDLE, 32'h0, 1'b0);
    HSIZE_M0 = 3'b010; HSIZE_M1 = 3'b010;
    HWDATA_M0 = 32'hDEADBEEF; HWDATA_M1 = 32'h0;
    HREADYOUT_S = 1'b1; HRESP_S = OKAY;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_rdy0", {31'd0, HREADY_M0}, 32'd1);
    chk("rst_rdy1", {31'd0, HREADY_M1}, 32'd1);
    chk("rst_resp", {28'd0, HRESP_M0, HRESP_M1}, 32'd0);
    chk("rst_sel", {31'd0, HSEL_S}, 32'd0);
    chk("rst_trans", {30'd0, HTRANS_S}, 32'd0);
    chk("rst_wdata", HWDATA_S, 32'd0);
    HRESETn = 1'b1; HWDATA_M0 = 32'h0;

    // 1: M1 alone passes straight through
    tick(); drv_m1(NSQ, 32'h100, 1'b0);
    push_s(32'h100, 1'b0); push_m(1, 1'b0, exp_rd(32'h100), OKAY);
    #1;
    chk("t1_addr", HADDR_S, 32'h100);
    chk("t1_sel", {31'd0, HSEL_S}, 32'd1);
    chk("t1_rdy1", {31'd0, HREADY_M1}, 32'd1);
    tick(); drv_m1(IDLE, 32'h0, 1'b0); #1;
    chk("t1_rdy1_dp", {31'd0, HREADY_M1}, 32'd1);
    chk("t1_rdata", HRDATA_M, 32'hCAFE0001);
    chk("t1_idle", {31'd0, HSEL_S}, 32'd0);
    tick();

    // 2: simultaneous requests; M1 (issued as SEQ) is captured and replayed
    tick(); drv_m0(NSQ, 32'h200, 1'b0); drv_m1(SEQ, 32'h300, 1'b0);
    push_s(32'h200, 1'b0); push_s(32'h300, 1'b0);
    push_m(0, 1'b0, exp_rd(32'h200), OKAY); push_m(1, 1'b0, exp_rd(32'h300), OKAY);
    #1;
    chk("t2_addr0", HADDR_S, 32'h200);
    tick(); drv_m0(IDLE, 32'h0, 1'b0); drv_m1(IDLE, 32'h0, 1'b0); #1;
    chk("t2_pend1", {31'd0, dut.r_pend_m1}, 32'd1);
    chk("t2_rdy1", {31'd0, HREADY_M1}, 32'd0);
    chk("t2_addr1", HADDR_S, 32'h300);
    chk("t2_trans", {30'd0, HTRANS_S}, {30'd0, NSQ});
    chk("t2_rdata0", HRDATA_M, 32'hCAFE0002);
    tick(); #1;
    chk("t2_rdy1b", {31'd0, HREADY_M1}, 32'd1);
    chk("t2_rdata1", HRDATA_M, 32'hCAFE0003);
    tick();

    // 3: M0 streams; starved M1 wins the slot after MAX_WAIT losses
    for (int k = 0; k < 6; k++) begin
      tick();
      drv_m0(NSQ, 32'h1000 + 32'(4 * k), 1'b0);
      if (k == 0) drv_m1(NSQ, 32'h500, 1'b0); else drv_m1(IDLE, 32'h0, 1'b0);
      push_m(0, 1'b0, exp_rd(32'h1000 + 32'(4 * k)), OKAY);
      if (k == 0) push_m(1, 1'b0, exp_rd(32'h500), OKAY);
      if (k < 5) push_s(32'h1000 + 32'(4 * k), 1'b0); else push_s(32'h500, 1'b0);
      #1;
      if (k >= 1) chk("t3_wait", {28'd0, dut.r_wait_cnt}, 32'(k - 1));
    end
    chk("t3_addr_m1", HADDR_S, 32'h500);
    tick(); drv_m0(IDLE, 32'h0, 1'b0); push_s(32'h1014, 1'b0); #1;
    chk("t3_wait_clr", {28'd0, dut.r_wait_cnt}, 32'd0);
    chk("t3_pend0", {31'd0, dut.r_pend_m0}, 32'd1);
    chk("t3_rdy0", {31'd0, HREADY_M0}, 32'd0);
    chk("t3_replay", HADDR_S, 32'h1014);
    tick(); tick();

    // 4: M0 write with three wait states; M1 captured during the stall
    tick(); drv_m0(NSQ, 32'h400, 1'b1);
    push_s(32'h400, 1'b1); push_m(0, 1'b1, 32'h0, OKAY);
    tick(); drv_m0(IDLE, 32'h0, 1'b0); HWDATA_M0 = 32'h12345678; HREADYOUT_S = 1'b0;
    drv_m1(NSQ, 32'h600, 1'b0); push_m(1, 1'b0, exp_rd(32'h600), OKAY);
    #1;
    chk("t4_wdata", HWDATA_S, 32'h12345678);
    chk("t4_rdy0", {31'd0, HREADY_M0}, 32'd0);
    chk("t4_sel", {31'd0, HSEL_S}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); drv_m1(IDLE, 32'h0, 1'b0); #1;
      chk("t4_wdata_w", HWDATA_S, 32'h12345678);
      chk("t4_rdy0_w", {31'd0, HREADY_M0}, 32'd0);
      chk("t4_rdy1_w", {31'd0, HREADY_M1}, 32'd0);
      chk("t4_hold_addr", HADDR_S, 32'h400);
    end
    tick(); HREADYOUT_S = 1'b1; push_s(32'h600, 1'b0); #1;
    chk("t4_rdy0_done", {31'd0, HREADY_M0}, 32'd1);
    chk("t4_wdata_end", HWDATA_S, 32'h12345678);
    chk("t4_addr1", HADDR_S, 32'h600);
    tick(); HWDATA_M0 = 32'h0; #1;
    chk("t4_rdy1", {31'd0, HREADY_M1}, 32'd1);
    tick();

    // 5: ERROR goes only to M0; M1's held transfer still issues
    tick(); drv_m0(NSQ, 32'h700, 1'b0); drv_m1(NSQ, 32'h800, 1'b0);
    push_s(32'h700, 1'b0); push_s(32'h800, 1'b0);
    push_m(0, 1'b0, 32'h0, ERR); push_m(1, 1'b0, exp_rd(32'h800), OKAY);
    tick(); drv_m0(IDLE, 32'h0, 1'b0); drv_m1(IDLE, 32'h0, 1'b0);
    HREADYOUT_S = 1'b0; HRESP_S = ERR; #1;
    chk("t5_resp0_a", {30'd0, HRESP_M0}, {30'd0, ERR});
    chk("t5_rdy0_a", {31'd0, HREADY_M0}, 32'd0);
    chk("t5_resp1_a", {30'd0, HRESP_M1}, {30'd0, OKAY});
    tick(); HREADYOUT_S = 1'b1; #1;
    chk("t5_resp0_b", {30'd0, HRESP_M0}, {30'd0, ERR});
    chk("t5_resp1_b", {30'd0, HRESP_M1}, {30'd0, OKAY});
    chk("t5_replay", HADDR_S, 32'h800);
    tick(); HRESP_S = OKAY; #1;
    chk("t5_rdy1", {31'd0, HREADY_M1}, 32'd1);
    tick();

    // 6: reset with M0 owning and M1 pending discards the held beat
    tick(); drv_m0(NSQ, 32'h900, 1'b0); drv_m1(NSQ, 32'hA00, 1'b0);
    push_s(32'h900, 1'b0);
    tick(); drv_m0(IDLE, 32'h0, 1'b0); drv_m1(IDLE, 32'h0, 1'b0); HREADYOUT_S = 1'b0; #1;
    chk("t6_pend1", {31'd0, dut.r_pend_m1}, 32'd1);
    chk("t6_owner", {30'd0, dut.r_owner}, 32'd1);
    HRESETn = 1'b0; HREADYOUT_S = 1'b1; #1;
    chk("t6_sel", {31'd0, HSEL_S}, 32'd0);
    chk("t6_trans", {30'd0, HTRANS_S}, 32'd0);
    chk("t6_rdy", {30'd0, HREADY_M0, HREADY_M1}, 32'd3);
    tick(); tick(); HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_replay", {31'd0, HSEL_S}, 32'd0);
    end

    chk("sq_empty", 32'(sq.size()), 32'd0);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
